// File: rtl/register_file_pkg.sv
// Shared constants for the architectural register file and its read ports.
// Optional feature macro: RF_COMMIT_BYPASS_EN (commit-to-query forwarding).
package register_file_pkg;

  localparam int XLEN         = 32;
  localparam int ROB_ID_W     = 5;
  localparam int REG_ID_W     = 5;
  localparam int NUM_REGS     = 32;
  localparam int NUM_RD_PORTS = 2;

  // ROB id 0 is reserved to mean "value is architectural, no pending writer".
  localparam logic [ROB_ID_W-1:0] NO_DEP = '0;

  // x0 is hard-wired to zero; every other register holds real state.
  function automatic logic is_arch_reg(input logic [REG_ID_W-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One dependency-query port: masks x0 and, when RF_COMMIT_BYPASS_EN is
// defined, forwards a same-cycle commit that resolves the queried tag.
module rf_read_port
  import register_file_pkg::*;
#(
  parameter int XLEN     = register_file_pkg::XLEN,
  parameter int ROB_ID_W = register_file_pkg::ROB_ID_W
) (
  input  logic [REG_ID_W-1:0] ask_rd,
  input  logic [ROB_ID_W-1:0] tag_rd,
  input  logic [XLEN-1:0]     value_rd,
`ifdef RF_COMMIT_BYPASS_EN
  input  logic                commit_ready,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [REG_ID_W-1:0] commit_register_id,
  input  logic [XLEN-1:0]     commit_value,
`endif
  output logic [ROB_ID_W-1:0] dep_rd,
  output logic [XLEN-1:0]     dep_value
);

  // Read the selected entry; x0 always reads as architectural zero.
  always_comb begin
    dep_rd    = ROB_ID_W'(NO_DEP);
    dep_value = '0;
    if (is_arch_reg(ask_rd)) begin
      dep_rd    = tag_rd;
      dep_value = value_rd;
`ifdef RF_COMMIT_BYPASS_EN
      // The writer we depend on retires this cycle: hand its value straight
      // to the decoder instead of waiting for the register write.
      if (commit_ready && (commit_register_id == ask_rd) &&
          (tag_rd == commit_rob_id)) begin
        dep_rd    = ROB_ID_W'(NO_DEP);
        dep_value = commit_value;
      end
`endif
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Stores 32 values plus the ROB id of each register's youngest in-flight
// writer; answers two combinational dependency queries per cycle.
// Optional feature macro: RF_COMMIT_BYPASS_EN (commit-to-query forwarding).
module register_file
  import register_file_pkg::*;
#(
  parameter int XLEN     = register_file_pkg::XLEN,
  parameter int ROB_ID_W = register_file_pkg::ROB_ID_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                _clear,
  input  logic                _rf_launch_ready,
  input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
  input  logic [REG_ID_W-1:0] _rf_launch_register_id,
  input  logic                _rf_commit_ready,
  input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
  input  logic [REG_ID_W-1:0] _rf_commit_register_id,
  input  logic [XLEN-1:0]     _rf_commit_value,
  input  logic [REG_ID_W-1:0] _ask_rd_1,
  input  logic [REG_ID_W-1:0] _ask_rd_2,
  output logic [ROB_ID_W-1:0] _dep_rd_1,
  output logic [ROB_ID_W-1:0] _dep_rd_2,
  output logic [XLEN-1:0]     _dep_value_1,
  output logic [XLEN-1:0]     _dep_value_2
);

  logic [NUM_REGS-1:0][XLEN-1:0]     value_q;
  logic [NUM_REGS-1:0][ROB_ID_W-1:0] tag_q;

  // Register state update. Entry 0 is never written so x0 stays 0/0.
  // Tag priority: clear > launch > commit-clear (a younger launch to the
  // same register must survive the older writer's retirement).
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      value_q <= '0;
      tag_q   <= '0;
    end else if (rdy_in) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (_rf_commit_ready && (_rf_commit_register_id == REG_ID_W'(r)))
          value_q[r] <= _rf_commit_value;
        if (_clear)
          tag_q[r] <= ROB_ID_W'(NO_DEP);
        else if (_rf_launch_ready && (_rf_launch_register_id == REG_ID_W'(r)))
          tag_q[r] <= _rf_launch_rob_id;
        else if (_rf_commit_ready && (_rf_commit_register_id == REG_ID_W'(r)) &&
                 (tag_q[r] == _rf_commit_rob_id))
          tag_q[r] <= ROB_ID_W'(NO_DEP);
      end
    end
  end

  logic [NUM_RD_PORTS-1:0][REG_ID_W-1:0] ask;
  logic [NUM_RD_PORTS-1:0][ROB_ID_W-1:0] dep_rd;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]     dep_value;

  assign ask = {_ask_rd_2, _ask_rd_1};

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    rf_read_port #(
      .XLEN     (XLEN),
      .ROB_ID_W (ROB_ID_W)
    ) u_rd (
      .ask_rd             (ask[p]),
      .tag_rd             (tag_q[ask[p]]),
      .value_rd           (value_q[ask[p]]),
`ifdef RF_COMMIT_BYPASS_EN
      .commit_ready       (_rf_commit_ready),
      .commit_rob_id      (_rf_commit_rob_id),
      .commit_register_id (_rf_commit_register_id),
      .commit_value       (_rf_commit_value),
`endif
      .dep_rd             (dep_rd[p]),
      .dep_value          (dep_value[p])
    );
  end

  assign _dep_rd_1    = dep_rd[0];
  assign _dep_rd_2    = dep_rd[1];
  assign _dep_value_1 = dep_value[0];
  assign _dep_value_2 = dep_value[1];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        launch_ready;
  logic [4:0]  launch_rob_id, launch_register_id;
  logic        commit_ready;
  logic [4:0]  commit_rob_id, commit_register_id;
  logic [31:0] commit_value;
  logic [4:0]  ask_rd_1, ask_rd_2;
  logic [4:0]  dep_rd_1, dep_rd_2;
  logic [31:0] dep_value_1, dep_value_2;

  int n_cmp = 0;
  int n_err = 0;

  register_file dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    ._clear                 (clear),
    ._rf_launch_ready       (launch_ready),
    ._rf_launch_rob_id      (launch_rob_id),
    ._rf_launch_register_id (launch_register_id),
    ._rf_commit_ready       (commit_ready),
    ._rf_commit_rob_id      (commit_rob_id),
    ._rf_commit_register_id (commit_register_id),
    ._rf_commit_value       (commit_value),
    ._ask_rd_1              (ask_rd_1),
    ._ask_rd_2              (ask_rd_2),
    ._dep_rd_1              (dep_rd_1),
    ._dep_rd_2              (dep_rd_2),
    ._dep_value_1           (dep_value_1),
    ._dep_value_2           (dep_value_2)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    clear        = 1'b0;
    launch_ready = 1'b0; launch_rob_id = '0; launch_register_id = '0;
    commit_ready = 1'b0; commit_rob_id = '0; commit_register_id = '0;
    commit_value = '0;
  endtask

  task automatic launch(input logic [4:0] r, input logic [4:0] id);
    launch_ready = 1'b1; launch_register_id = r; launch_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] id, input logic [31:0] v);
    commit_ready = 1'b1; commit_register_id = r; commit_rob_id = id; commit_value = v;
  endtask

  task automatic test_reset();
    ask_rd_1 = 5'd5; ask_rd_2 = 5'd6; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL reset_dep1: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_rd_2 !== 5'd0) begin n_err++; $display("FAIL reset_dep2: got %0d want 0", dep_rd_2); end
    n_cmp++; if (dep_value_1 !== 32'd0) begin n_err++; $display("FAIL reset_val1: got %0h want 0", dep_value_1); end
    n_cmp++; if (dep_value_2 !== 32'd0) begin n_err++; $display("FAIL reset_val2: got %0h want 0", dep_value_2); end
  endtask

  task automatic test_launch_commit();
    launch(5'd5, 5'd3); tick(); idle();
    ask_rd_1 = 5'd5; #1;
    n_cmp++; if (dep_rd_1 !== 5'd3) begin n_err++; $display("FAIL launch_tag: got %0d want 3", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'd0) begin n_err++; $display("FAIL launch_val: got %0h want 0", dep_value_1); end
    commit(5'd5, 5'd3, 32'h1234); tick(); idle(); #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL commit_tag: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'h1234) begin n_err++; $display("FAIL commit_val: got %0h want 1234", dep_value_1); end
  endtask

  task automatic test_younger_writer();
    launch(5'd7, 5'd4); tick(); idle();
    launch(5'd7, 5'd9); tick(); idle();
    commit(5'd7, 5'd4, 32'hAA); tick(); idle();
    ask_rd_2 = 5'd7; #1;
    n_cmp++; if (dep_rd_2 !== 5'd9) begin n_err++; $display("FAIL younger_tag: got %0d want 9", dep_rd_2); end
    n_cmp++; if (dep_value_2 !== 32'hAA) begin n_err++; $display("FAIL younger_val: got %0h want aa", dep_value_2); end
  endtask

  task automatic test_same_cycle();
    commit(5'd8, 5'd2, 32'h55); launch(5'd8, 5'd6); tick(); idle();
    ask_rd_1 = 5'd8; #1;
    n_cmp++; if (dep_rd_1 !== 5'd6) begin n_err++; $display("FAIL same_reg_tag: got %0d want 6", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'h55) begin n_err++; $display("FAIL same_reg_val: got %0h want 55", dep_value_1); end
    // different registers in one cycle act independently
    commit(5'd8, 5'd6, 32'h66); launch(5'd10, 5'd11); tick(); idle();
    ask_rd_1 = 5'd8; ask_rd_2 = 5'd10; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL diff_reg_commit_tag: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'h66) begin n_err++; $display("FAIL diff_reg_commit_val: got %0h want 66", dep_value_1); end
    n_cmp++; if (dep_rd_2 !== 5'd11) begin n_err++; $display("FAIL diff_reg_launch_tag: got %0d want 11", dep_rd_2); end
  endtask

  task automatic test_clear();
    launch(5'd1, 5'd1); tick(); idle();
    launch(5'd2, 5'd2); tick(); idle();
    launch(5'd3, 5'd3); tick(); idle();
    ask_rd_1 = 5'd3; #1;
    n_cmp++; if (dep_rd_1 !== 5'd3) begin n_err++; $display("FAIL pre_clear_tag: got %0d want 3", dep_rd_1); end
    clear = 1'b1; launch(5'd4, 5'd5); commit(5'd2, 5'd9, 32'h22); tick(); idle();
    ask_rd_1 = 5'd1; ask_rd_2 = 5'd2; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL clear_x1: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_rd_2 !== 5'd0) begin n_err++; $display("FAIL clear_x2: got %0d want 0", dep_rd_2); end
    n_cmp++; if (dep_value_2 !== 32'h22) begin n_err++; $display("FAIL clear_commit_val: got %0h want 22", dep_value_2); end
    ask_rd_1 = 5'd3; ask_rd_2 = 5'd4; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL clear_x3: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_rd_2 !== 5'd0) begin n_err++; $display("FAIL clear_drop_launch: got %0d want 0", dep_rd_2); end
    ask_rd_1 = 5'd10; ask_rd_2 = 5'd7; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL clear_x10: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_2 !== 32'hAA) begin n_err++; $display("FAIL clear_keeps_val: got %0h want aa", dep_value_2); end
  endtask

  task automatic test_x0();
    launch(5'd0, 5'd5); commit(5'd0, 5'd0, 32'hFFFF); tick(); idle();
    ask_rd_1 = 5'd0; ask_rd_2 = 5'd0; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL x0_tag1: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'd0) begin n_err++; $display("FAIL x0_val1: got %0h want 0", dep_value_1); end
    n_cmp++; if (dep_value_2 !== 32'd0) begin n_err++; $display("FAIL x0_val2: got %0h want 0", dep_value_2); end
  endtask

  task automatic test_rdy_low();
    rdy_in = 1'b0; launch(5'd12, 5'd13); commit(5'd5, 5'd0, 32'hDEAD); tick(); idle();
    rdy_in = 1'b1;
    ask_rd_1 = 5'd12; ask_rd_2 = 5'd5; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL rdy_low_tag: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_2 !== 32'h1234) begin n_err++; $display("FAIL rdy_low_val: got %0h want 1234", dep_value_2); end
  endtask

  task automatic test_reset_priority();
    launch(5'd13, 5'd14); tick(); idle();
    ask_rd_1 = 5'd13; #1;
    n_cmp++; if (dep_rd_1 !== 5'd14) begin n_err++; $display("FAIL pre_reset_tag: got %0d want 14", dep_rd_1); end
    rst_in = 1'b1; launch(5'd13, 5'd15); commit(5'd8, 5'd0, 32'h1); tick(); idle();
    rst_in = 1'b0;
    ask_rd_1 = 5'd13; ask_rd_2 = 5'd8; #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL reset_prio_tag: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_2 !== 32'd0) begin n_err++; $display("FAIL reset_prio_val: got %0h want 0", dep_value_2); end
    ask_rd_2 = 5'd5; #1;
    n_cmp++; if (dep_value_2 !== 32'd0) begin n_err++; $display("FAIL reset_clears_x5: got %0h want 0", dep_value_2); end
  endtask

  task automatic test_bypass();
    logic [4:0]  exp_tag;
    logic [31:0] exp_val;
`ifdef RF_COMMIT_BYPASS_EN
    exp_tag = 5'd0; exp_val = 32'hBEEF;
`else
    exp_tag = 5'd7; exp_val = 32'd0;
`endif
    launch(5'd9, 5'd7); tick(); idle();
    commit(5'd9, 5'd7, 32'hBEEF); ask_rd_1 = 5'd9; ask_rd_2 = 5'd9; #1;
    n_cmp++; if (dep_rd_1 !== exp_tag) begin n_err++; $display("FAIL bypass_tag: got %0d want %0d", dep_rd_1, exp_tag); end
    n_cmp++; if (dep_value_2 !== exp_val) begin n_err++; $display("FAIL bypass_val: got %0h want %0h", dep_value_2, exp_val); end
    tick(); idle(); #1;
    n_cmp++; if (dep_rd_1 !== 5'd0) begin n_err++; $display("FAIL post_bypass_tag: got %0d want 0", dep_rd_1); end
    n_cmp++; if (dep_value_1 !== 32'hBEEF) begin n_err++; $display("FAIL post_bypass_val: got %0h want beef", dep_value_1); end
  endtask

  initial begin
    idle();
    rst_in = 1'b1; rdy_in = 1'b1; ask_rd_1 = 5'd5; ask_rd_2 = 5'd6;
    tick(); tick();
    rst_in = 1'b0;
    test_reset();
    test_launch_commit();
    test_younger_writer();
    test_same_cycle();
    test_clear();
    test_x0();
    test_rdy_low();
    test_reset_priority();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
